// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one registered-output ALU between two requesters.
// Round-robin grant, valid/ready on both request and response sides, a
// one-entry result buffer per requester, tag passthrough, issue counter.
//
// Ports
//   clk, rst_n          clock (rising edge), async active-low reset
//   req_valid/req_ready request handshake per requester (ready = grant)
//   req_x/req_y         operands, requester r at [r*XLEN +: XLEN]
//   req_funct3/funct7   opcode fields, passed to the ALU untouched
//   req_imm, req_id     imm flag and tag per requester
//   rsp_valid/rsp_ready response handshake per requester
//   rsp_data/rsp_id     buffered result and its tag, packed as req_x/req_id
//   alu_*               operand/opcode drive to the ALU, alu_out its result
//   issue_cnt           number of accepted requests, wraps at 2^32
module alu_arbiter #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned ID_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [2*XLEN-1:0]    req_x,
  input  logic [2*XLEN-1:0]    req_y,
  input  logic [5:0]           req_funct3,
  input  logic [13:0]          req_funct7,
  input  logic [1:0]           req_imm,
  input  logic [2*ID_W-1:0]    req_id,
  output logic [1:0]           rsp_valid,
  input  logic [1:0]           rsp_ready,
  output logic [2*XLEN-1:0]    rsp_data,
  output logic [2*ID_W-1:0]    rsp_id,
  output logic [XLEN-1:0]      alu_x,
  output logic [XLEN-1:0]      alu_y,
  output logic [2:0]           alu_funct3,
  output logic [6:0]           alu_funct7,
  output logic                 alu_imm,
  input  logic [XLEN-1:0]      alu_out,
  output logic [31:0]          issue_cnt
);

  localparam int unsigned CNT_W = 32;

  logic [1:0]            rsp_valid_q, rsp_valid_d;
  logic [1:0][XLEN-1:0]  rsp_data_q,  rsp_data_d;
  logic [1:0][ID_W-1:0]  rsp_id_q,    rsp_id_d;
  logic                  inf_valid_q, inf_valid_d;
  logic                  inf_req_q,   inf_req_d;
  logic [ID_W-1:0]       inf_id_q,    inf_id_d;
  logic                  ptr_q,       ptr_d;
  logic [CNT_W-1:0]      issue_cnt_q, issue_cnt_d;

  logic [1:0]            elig;
  logic [1:0]            gnt;
  logic                  gnt_any;
  logic                  gnt_idx;
  logic [1:0]            cap_c;
  logic [1:0]            hs_c;

  // A requester is blocked while its own op is in flight, or while its
  // buffer is full and not being drained this cycle.
  always_comb begin
    elig = 2'b00;
    for (int r = 0; r < 2; r++) begin
      elig[r] = req_valid[r]
              && !(inf_valid_q && (inf_req_q == 1'(r)))
              && (!rsp_valid_q[r] || rsp_ready[r]);
    end
  end

  // Round-robin: ptr_q names the requester preferred on a tie.
  always_comb begin
    gnt = elig;
    if (elig == 2'b11) begin
      gnt = ptr_q ? 2'b10 : 2'b01;
    end
  end

  assign gnt_any   = |gnt;
  assign gnt_idx   = gnt[1];
  assign req_ready = gnt;

  // ALU operand mux; all zeros when idle.
  always_comb begin
    alu_x      = '0;
    alu_y      = '0;
    alu_funct3 = '0;
    alu_funct7 = '0;
    alu_imm    = 1'b0;
    if (gnt_any) begin
      alu_x      = gnt_idx ? req_x[2*XLEN-1:XLEN] : req_x[XLEN-1:0];
      alu_y      = gnt_idx ? req_y[2*XLEN-1:XLEN] : req_y[XLEN-1:0];
      alu_funct3 = gnt_idx ? req_funct3[5:3]      : req_funct3[2:0];
      alu_funct7 = gnt_idx ? req_funct7[13:7]     : req_funct7[6:0];
      alu_imm    = gnt_idx ? req_imm[1]           : req_imm[0];
    end
  end

  // Next-state: in-flight tracking, pointer update, result capture.
  always_comb begin
    inf_valid_d = gnt_any;
    inf_req_d   = gnt_any ? gnt_idx : 1'b0;
    inf_id_d    = '0;
    if (gnt_any) begin
      inf_id_d = gnt_idx ? req_id[2*ID_W-1:ID_W] : req_id[ID_W-1:0];
    end
    ptr_d       = gnt_any ? ~gnt_idx : ptr_q;
    rsp_valid_d = rsp_valid_q & ~rsp_ready;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    if (inf_valid_q) begin
      rsp_valid_d[inf_req_q] = 1'b1;
      rsp_data_d[inf_req_q]  = alu_out;
      rsp_id_d[inf_req_q]    = inf_id_q;
    end
  end

  // Kept as a continuous assignment so the counter can be preloaded from a bench.
  assign issue_cnt_d = issue_cnt_q + CNT_W'(gnt_any);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
      inf_valid_q <= 1'b0;
      inf_req_q   <= 1'b0;
      inf_id_q    <= '0;
      ptr_q       <= 1'b0;
      issue_cnt_q <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
      inf_valid_q <= inf_valid_d;
      inf_req_q   <= inf_req_d;
      inf_id_q    <= inf_id_d;
      ptr_q       <= ptr_d;
      issue_cnt_q <= issue_cnt_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign issue_cnt = issue_cnt_q;

  // A capture into a buffer must never coincide with that buffer draining.
  assign cap_c = inf_valid_q ? (inf_req_q ? 2'b10 : 2'b01) : 2'b00;
  assign hs_c  = rsp_valid_q & rsp_ready;

  a_no_cap_on_drain: assert property (@(posedge clk) disable iff (!rst_n)
    (cap_c & hs_c) == 2'b00);

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;
  localparam int unsigned XLEN = 32;
  localparam int unsigned ID_W = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [1:0]        req_valid = '0, req_ready, req_imm = '0;
  logic [1:0]        rsp_valid, rsp_ready = 2'b11;
  logic [2*XLEN-1:0] req_x = '0, req_y = '0, rsp_data;
  logic [5:0]        req_funct3 = '0;
  logic [13:0]       req_funct7 = '0;
  logic [2*ID_W-1:0] req_id = '0, rsp_id;
  logic [XLEN-1:0]   alu_x, alu_y, alu_out = '0;
  logic [2:0]        alu_funct3;
  logic [6:0]        alu_funct7;
  logic              alu_imm;
  logic [31:0]       issue_cnt;

  int errors = 0;
  int checks = 0;

  // Reference model state: visible buffers, pending (in-flight) results.
  bit          m_rv[2];
  logic [31:0] m_rd[2];
  logic [3:0]  m_rid[2];
  bit          m_pv[2];
  logic [31:0] m_pd[2];
  logic [3:0]  m_pid[2];
  int          m_last;
  logic [31:0] m_cnt;

  always #5 clk = ~clk;

  alu_arbiter #(.XLEN(XLEN), .ID_W(ID_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y),
    .req_funct3(req_funct3), .req_funct7(req_funct7),
    .req_imm(req_imm), .req_id(req_id),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id),
    .alu_x(alu_x), .alu_y(alu_y),
    .alu_funct3(alu_funct3), .alu_funct7(alu_funct7), .alu_imm(alu_imm),
    .alu_out(alu_out), .issue_cnt(issue_cnt)
  );

  // RV32 integer ALU behaviour.
  function automatic logic [31:0] alu_ref(input logic [31:0] x, input logic [31:0] y,
                                          input logic [2:0] f3, input logic [6:0] f7,
                                          input logic imm);
    case (f3)
      3'd0:    return (f7[5] && !imm) ? x - y : x + y;
      3'd1:    return x << y[4:0];
      3'd2:    return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      3'd3:    return (x < y) ? 32'd1 : 32'd0;
      3'd4:    return x ^ y;
      3'd5:    return f7[5] ? 32'($signed(x) >>> y[4:0]) : x >> y[4:0];
      3'd6:    return x | y;
      default: return x & y;
    endcase
  endfunction

  // The shared ALU: one-cycle registered result.
  always_ff @(posedge clk) alu_out <= alu_ref(alu_x, alu_y, alu_funct3, alu_funct7, alu_imm);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < 2; r++) begin
      m_rv[r] = 0; m_rd[r] = '0; m_rid[r] = '0;
      m_pv[r] = 0; m_pd[r] = '0; m_pid[r] = '0;
    end
    m_last = 1;
    m_cnt  = '0;
  endtask

  // Requester to be served this cycle, -1 for none.
  function automatic int exp_grant();
    bit e[2];
    for (int r = 0; r < 2; r++)
      e[r] = req_valid[r] && !m_pv[r] && (!m_rv[r] || rsp_ready[r]);
    if (e[0] && e[1]) return 1 - m_last;
    if (e[0]) return 0;
    if (e[1]) return 1;
    return -1;
  endfunction

  // One clock: check every output against the model, then advance the model.
  task automatic tick();
    int          g;
    logic [1:0]  er;
    logic [31:0] ex, ey;
    logic [2:0]  ef3;
    logic [6:0]  ef7;
    logic        eimm;
    #1;
    if (!rst_n) model_reset();
    g = exp_grant();
    er = 2'b00; ex = '0; ey = '0; ef3 = '0; ef7 = '0; eimm = 1'b0;
    if (g >= 0) begin
      er   = (g == 0) ? 2'b01 : 2'b10;
      ex   = req_x[g*XLEN +: XLEN];
      ey   = req_y[g*XLEN +: XLEN];
      ef3  = req_funct3[g*3 +: 3];
      ef7  = req_funct7[g*7 +: 7];
      eimm = req_imm[g];
    end
    chk("req_ready",  64'(req_ready),  64'(er));
    chk("alu_x",      64'(alu_x),      64'(ex));
    chk("alu_y",      64'(alu_y),      64'(ey));
    chk("alu_funct3", 64'(alu_funct3), 64'(ef3));
    chk("alu_funct7", 64'(alu_funct7), 64'(ef7));
    chk("alu_imm",    64'(alu_imm),    64'(eimm));
    chk("rsp_valid",  64'(rsp_valid),  64'({m_rv[1], m_rv[0]}));
    chk("rsp_data",   rsp_data,        {m_rd[1], m_rd[0]});
    chk("rsp_id",     64'(rsp_id),     64'({m_rid[1], m_rid[0]}));
    chk("issue_cnt",  64'(issue_cnt),  64'(m_cnt));
    @(posedge clk);
    if (rst_n) begin
      for (int r = 0; r < 2; r++)
        if (m_rv[r] && rsp_ready[r]) m_rv[r] = 0;
      for (int r = 0; r < 2; r++)
        if (m_pv[r]) begin
          m_rv[r] = 1; m_rd[r] = m_pd[r]; m_rid[r] = m_pid[r]; m_pv[r] = 0;
        end
      if (g >= 0) begin
        m_pv[g]  = 1;
        m_pd[g]  = alu_ref(ex, ey, ef3, ef7, eimm);
        m_pid[g] = req_id[g*ID_W +: ID_W];
        m_cnt    = m_cnt + 32'd1;
        m_last   = g;
      end
    end
    @(negedge clk);
  endtask

  task automatic drive(input int r, input logic [31:0] x, input logic [31:0] y,
                       input logic [2:0] f3, input logic [6:0] f7, input logic imm,
                       input logic [3:0] id);
    req_valid[r]        = 1'b1;
    req_x[r*XLEN +: XLEN] = x;
    req_y[r*XLEN +: XLEN] = y;
    req_funct3[r*3 +: 3]  = f3;
    req_funct7[r*7 +: 7]  = f7;
    req_imm[r]            = imm;
    req_id[r*ID_W +: ID_W] = id;
  endtask

  task automatic rand_req(input int r);
    drive(r, $urandom, $urandom, 3'($urandom_range(0, 7)),
          ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00,
          1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
  endtask

  task automatic do_reset();
    req_valid = 2'b00;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    @(negedge clk);

    // Reset state
    #1;
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_rsp_data",  rsp_data,       64'd0);
    chk("reset_issue_cnt", 64'(issue_cnt), 64'd0);
    tick();
    rst_n = 1'b1;

    // Single ADD from requester 0
    drive(0, 32'd5, 32'd7, 3'd0, 7'd0, 1'b0, 4'd3);
    #1 chk("t1_req_ready", 64'(req_ready), 64'b01);
    tick();
    req_valid = 2'b00;
    tick();
    #1;
    chk("t1_rsp_valid0", 64'(rsp_valid[0]), 64'd1);
    chk("t1_rsp_data0",  64'(rsp_data[31:0]), 64'd12);
    chk("t1_rsp_id0",    64'(rsp_id[3:0]), 64'd3);
    chk("t1_issue_cnt",  64'(issue_cnt), 64'd1);
    tick();

    // Both requesters valid straight out of reset
    do_reset();
    drive(0, 32'd1, 32'd1, 3'd0, 7'd0, 1'b0, 4'd1);
    drive(1, 32'hF0, 32'hFF, 3'd4, 7'd0, 1'b0, 4'd2);
    #1 chk("t2_grant_T", 64'(req_ready), 64'b01);
    tick();
    #1 chk("t2_grant_T1", 64'(req_ready), 64'b10);
    tick();
    #1;
    chk("t2_grant_T2", 64'(req_ready), 64'b01);
    chk("t2_rsp0", 64'(rsp_data[31:0]), 64'd2);
    tick();
    #1 chk("t2_rsp1", 64'(rsp_data[63:32]), 64'h0F);
    req_valid = 2'b00;
    tick(); tick(); tick();

    // SUB on requester 0, signed SLT on requester 1
    drive(0, 32'd3, 32'd5, 3'd0, 7'h20, 1'b0, 4'd5);
    drive(1, 32'hFFFF_FFFF, 32'd1, 3'd2, 7'd0, 1'b0, 4'd6);
    tick(); tick();
    req_valid = 2'b00;
    tick(); tick();
    #1;
    chk("t3_sub", 64'(rsp_data[31:0]),  64'hFFFF_FFFE);
    chk("t3_slt", 64'(rsp_data[63:32]), 64'd1);
    tick();

    // Back-pressure on requester 0 while requester 1 keeps issuing
    rsp_ready = 2'b10;
    drive(0, 32'd5, 32'd7, 3'd0, 7'd0, 1'b0, 4'd3);
    tick();
    req_valid = 2'b00;
    tick();
    drive(0, 32'd9, 32'd9, 3'd0, 7'd0, 1'b0, 4'd9);
    for (int i = 0; i < 5; i++) begin
      rand_req(1);
      #1;
      chk("t4_stall_ready0", 64'(req_ready[0]), 64'd0);
      chk("t4_hold_data0",   64'(rsp_data[31:0]), 64'd12);
      chk("t4_hold_id0",     64'(rsp_id[3:0]), 64'd3);
      tick();
    end
    rsp_ready = 2'b11;
    #1 chk("t4_regrant0", 64'(req_ready), 64'b01);
    tick();
    req_valid = 2'b00;
    tick(); tick(); tick();

    // Reset while a requester-0 op is in flight
    drive(0, 32'd11, 32'd22, 3'd0, 7'd0, 1'b0, 4'd7);
    tick();
    req_valid = 2'b00;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", 64'(rsp_valid), 64'd0);
    chk("t5_rst_data",  rsp_data,       64'd0);
    chk("t5_rst_id",    64'(rsp_id),    64'd0);
    chk("t5_rst_cnt",   64'(issue_cnt), 64'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("t5_no_rsp", 64'(rsp_valid), 64'd0);
      tick();
    end
    drive(0, 32'd1, 32'd2, 3'd6, 7'd0, 1'b0, 4'd1);
    drive(1, 32'd3, 32'd4, 3'd7, 7'd0, 1'b0, 4'd2);
    #1 chk("t5_ptr_reset", 64'(req_ready), 64'b01);
    tick();
    req_valid = 2'b00;
    tick(); tick(); tick();

    // Counter wrap via preload
    force dut.issue_cnt_d = 32'hFFFF_FFFF;
    tick();
    release dut.issue_cnt_d;
    m_cnt = 32'hFFFF_FFFF;
    #1 chk("t6_preload", 64'(issue_cnt), 64'hFFFF_FFFF);
    drive(1, 32'd8, 32'd1, 3'd1, 7'd0, 1'b0, 4'd4);
    tick();
    req_valid = 2'b00;
    #1 chk("t6_wrap", 64'(issue_cnt), 64'd0);
    tick(); tick();

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      req_valid = 2'b00;
      for (int r = 0; r < 2; r++)
        if ($urandom_range(0, 3) != 0) rand_req(r);
      rsp_ready = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) rsp_ready = 2'b11;
      tick();
    end
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    tick(); tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one registered-output ALU (single-cycle latency: operands sampled at a posedge, result valid on its output for the following cycle) between two requesters, e.g. the execute stage and the branch/address unit.
- Round-robin grant, valid/ready handshakes on request and response sides, one-entry result buffer per requester, tag passthrough, and an issue counter.
- Sits between the requesters and the ALU instance; it never decodes funct3/funct7/imm and passes them through unchanged.

Parameters:
XLEN, 32, operand/result width
ID_W, 4, request tag width returned with the result

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
req_valid  in  2  request valid, bit r = requester r
req_ready  out  2  request accepted this cycle (one-hot or zero)
req_x  in  2*XLEN  operand x, requester r at [r*XLEN +: XLEN]
req_y  in  2*XLEN  operand y, same packing
req_funct3  in  6  funct3, [r*3 +: 3]
req_funct7  in  14  funct7, [r*7 +: 7]
req_imm  in  2  imm flag per requester
req_id  in  2*ID_W  tag, [r*ID_W +: ID_W]
rsp_valid  out  2  result buffer r holds a result
rsp_ready  in  2  requester r consumes its result
rsp_data  out  2*XLEN  result, packed as req_x
rsp_id  out  2*ID_W  tag of the buffered result
alu_x  out  XLEN  to ALU x
alu_y  out  XLEN  to ALU y
alu_funct3  out  3  to ALU funct3
alu_funct7  out  7  to ALU funct7
alu_imm  out  1  to ALU imm
alu_out  in  XLEN  from ALU out
issue_cnt  out  32  count of accepted requests

Behaviour:
- Reset (rst_n low, asynchronous): rsp_valid=0, rsp_data=0, rsp_id=0, in-flight register cleared, RR pointer=0 (requester 0 preferred), issue_cnt=0. An operation in flight at reset is dropped and produces no response.
- Eligibility of requester r: req_valid[r], no in-flight op targeting r, and (rsp_valid[r]==0 or rsp_ready[r]==1 this cycle). The rsp_ready->req_ready combinational path is intentional.
- Grant: at most one per cycle. If both are eligible, grant the requester the pointer prefers. After a grant to r the pointer prefers 1-r. With no grant, the pointer holds. req_ready = grant (combinational).
- ALU drive: alu_* are combinationally muxed from the granted requester. With no grant, drive all zeros (ALU computes 0+0; its result is ignored).
- Pipeline: handshake in cycle T. In-flight register {valid, r, id} is set at the end of T. alu_out is valid in T+1 and captured into buffer r at the end of T+1. rsp_valid[r] rises in T+2. Fixed latency is 2 cycles.
- Buffer r holds data/id stable while rsp_valid[r]=1 and rsp_ready[r]=0.
- rsp_valid[r] clears on handshake unless a capture for r occurs in the same cycle. That cannot happen, because an in-flight op for r blocks r; assert it in simulation.
- Throughput: each requester issues at most 1 op per 2 cycles. Alternating requesters sustain 1 op/cycle.
- issue_cnt increments by 1 on each accepted request and wraps from 0xFFFFFFFF to 0.
- Responses for different requesters are independent; response to r never stalls r' != r.

Test Plan:
- Reset release; req0: x=5, y=7, funct3=0, funct7=0, imm=0, id=3, rsp_ready=1 -> req_ready[0] in cycle T, rsp_valid[0] in T+2 with data=12, id=3; issue_cnt=1.
- Both valid from reset; req0 ADD 1+1, req1 XOR 0xF0^0xFF -> req0 granted T, req1 T+1; rsp0=2 at T+2, rsp1=0x0F at T+3; then req0 re-granted at T+2.
- req0 SUB: x=3, y=5, funct7=0x20, imm=0 -> rsp_data[0]=0xFFFFFFFE. req1 SLT: x=0xFFFFFFFF, y=1 -> rsp_data[1]=1.
- rsp_ready[0]=0 for 5 cycles after result 12 -> rsp0 holds 12/id stable, req_ready[0]=0 throughout while req1 keeps issuing; raising rsp_ready[0] re-grants req0 in the same cycle.
- Assert rst_n low the cycle after accepting a req0 op -> no rsp_valid[0] after release; all outputs 0; pointer back to requester 0.
- Force issue_cnt to 0xFFFFFFFF via back-to-back alternating traffic (or a forced preload), accept one more -> issue_cnt=0.
